md_issue_ctrl: RTL

Initiator side of the multiply/divide interface. It sits between the D/E pipeline stages and the multiply/divide unit, and presents each E-stage MD instruction to the unit as an MDOp code. It tracks the unit's fixed latency with its own countdown, stalls the D stage when an MD-class instruction would collide with an in-flight operation, and cross-checks the unit's Busy against its own shadow.

---
 rtl/md_issue_ctrl_pkg.sv | 39 +++
 rtl/md_issue_ctrl_if.sv | 26 ++
 rtl/md_issue_ctrl_lat_counter.sv | 26 ++
 rtl/md_issue_ctrl.sv | 73 +++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Op codes, FSM states and latency defaults shared by the multiply/divide issue controller.
// Helper functions classify op codes; codes 9-15 behave like MD_NONE.
package md_issue_ctrl_pkg;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF   = 4;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULTU = 4'd1;
  localparam md_op_t MD_MULT  = 4'd2;
  localparam md_op_t MD_DIVU  = 4'd3;
  localparam md_op_t MD_DIV   = 4'd4;
  localparam md_op_t MD_MFLO  = 4'd5;
  localparam md_op_t MD_MFHI  = 4'd6;
  localparam md_op_t MD_MTHI  = 4'd7;
  localparam md_op_t MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input md_op_t op);
    return (op >= MD_MULTU) && (op <= MD_MTLO);
  endfunction

  function automatic logic is_muldiv_op(input md_op_t op);
    return (op >= MD_MULTU) && (op <= MD_DIV);
  endfunction

  function automatic logic is_mul_op(input md_op_t op);
    return (op == MD_MULTU) || (op == MD_MULT);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline-side and unit-side signals of the multiply/divide issue controller.
// master = the controller, slave = the pipeline/unit environment driving it.
interface md_issue_ctrl_if;
  import md_issue_ctrl_pkg::*;

  md_op_t d_md_op;
  md_op_t e_md_op;
  logic   e_valid;
  logic   e_flush;
  logic   md_busy;
  logic   md_start;
  md_op_t md_op;
  logic   stall;
  logic   proto_err;

  modport master (
    input  d_md_op, e_md_op, e_valid, e_flush, md_busy,
    output md_start, md_op, stall, proto_err
  );

  modport slave (
    output d_md_op, e_md_op, e_valid, e_flush, md_busy,
    input  md_start, md_op, stall, proto_err
  );

endinterface

// File: rtl/md_issue_ctrl_lat_counter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
// Latency: count and zero flag update on the edge after load; no backpressure.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues E-stage MD ops to the mul/div unit, shadows its fixed latency and stalls D on MD collisions.
// Latency: md_op/md_start/stall are combinational; proto_err registers one edge after the fault.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  md_issue_ctrl_if.master md
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             busy_sh;
  logic             issue_ok;
  logic             violation;
  logic             start_w;
  logic [CNT_W-1:0] load_val;
  logic             err_q;

  assign busy_sh   = ~cnt_zero;
  assign issue_ok  = md.e_valid & ~md.e_flush & is_md_op(md.e_md_op);
  // An MD op in E while the unit is still counting must never reach it.
  assign violation = issue_ok & busy_sh;
  assign start_w   = issue_ok & is_muldiv_op(md.e_md_op) & ~busy_sh & ~reset;
  assign load_val  = is_mul_op(md.e_md_op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);

  assign md.md_start  = start_w;
  assign md.md_op     = (issue_ok & ~busy_sh & ~reset) ? md.e_md_op : MD_NONE;
  assign md.stall     = is_md_op(md.d_md_op) & (busy_sh | start_w) & ~reset;
  assign md.proto_err = err_q & ~reset;

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (start_w),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_w) begin
            state <= is_mul_op(md.e_md_op) ? MUL_WAIT : DIV_WAIT;
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // The issue cycle is exempt: the unit may already raise Busy on that cycle.
      if (violation || ((md.md_busy != busy_sh) && !start_w)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
